// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-requester memory bus arbiter.
package mem_bus_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        ACK
    } arb_state_t;

    // Requester index, also used as the bus owner encoding.
    localparam logic REQ_F = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_bus_grant_sel.sv
// Winner selection between fetch (F) and data (D) requesters.
// D wins by default; once D has been granted STARVE_LIMIT times in a row
// while F was waiting, F is forced through.
module mem_bus_grant_sel
    import mem_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_f_req,
    input  logic i_d_req,
    input  logic i_advance,
    output logic o_winner,
    output logic o_grant_valid
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_streak;
    logic       w_winner;

    // Combinational winner pick from current requests and streak count.
    always_comb begin
        // NOTE: assigning a default first guarantees every path drives the
        // signal, so no latch is inferred.
        w_winner = REQ_F;
        if (i_f_req && (r_streak == LIMIT)) begin
            w_winner = REQ_F;
        end else if (i_d_req) begin
            w_winner = REQ_D;
        end else begin
            w_winner = REQ_F;
        end
    end

    // Streak counter: counts D grants made while F was kept waiting.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            r_streak <= '0;
        end else if (i_advance) begin
            if ((w_winner == REQ_D) && i_f_req) begin
                r_streak <= (r_streak == LIMIT) ? LIMIT : r_streak + 4'd1;
            end else begin
                r_streak <= '0;
            end
        end
    end

    assign o_winner      = w_winner;
    assign o_grant_valid = i_f_req | i_d_req;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one Avalon-style memory bus between the fetch and load/store ports.
// One transaction at a time: IDLE -> ISSUE -> (RESP for reads) -> ACK.
// The done pulse is registered out of ACK, so it is visible in the cycle after
// ACK while the FSM is already back in IDLE.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [31:0]       f_rdata,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_byteenable,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic [ADDR_W-1:0] address,
    output logic              write,
    output logic              read,
    input  logic              waitrequest,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic [31:0]       readdata
);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_owner;
    logic              r_read;
    logic              r_write;
    logic [ADDR_W-1:0] r_address;
    logic [31:0]       r_writedata;
    logic [3:0]        r_byteenable;
    logic [31:0]       r_f_rdata;
    logic [31:0]       r_d_rdata;
    logic              r_f_done;
    logic              r_d_done;
    logic              w_winner;
    logic              w_grant_valid;
    logic              w_advance;
    logic              w_accept;

    mem_bus_grant_sel #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_grant_sel (
        .clk           (clk),
        .reset         (reset),
        .i_f_req       (f_req),
        .i_d_req       (d_req),
        .i_advance     (w_advance),
        .o_winner      (w_winner),
        .o_grant_valid (w_grant_valid)
    );

    // During the done cycle the finished requester still holds req, so no
    // grant is made then; otherwise the same request would be served twice.
    assign w_advance = (r_state == IDLE) && w_grant_valid && !(r_f_done || r_d_done);
    assign w_accept  = (r_state == ISSUE) && !waitrequest;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_advance) w_next_state = ISSUE;
            ISSUE:   if (w_accept)  w_next_state = r_write ? ACK : RESP;
            RESP:    w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Bus request registers: loaded on grant, strobes dropped on acceptance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner      <= REQ_D;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_address    <= '0;
            r_writedata  <= '0;
            r_byteenable <= '0;
        end else if (w_advance) begin
            r_owner <= w_winner;
            if (w_winner == REQ_D) begin
                r_address    <= d_addr;
                r_writedata  <= d_wdata;
                r_read       <= !d_write;
                r_write      <= d_write;
                r_byteenable <= d_write ? d_byteenable : BE_WORD;
            end else begin
                r_address    <= f_addr;
                r_writedata  <= '0;
                r_read       <= 1'b1;
                r_write      <= 1'b0;
                r_byteenable <= BE_WORD;
            end
        end else if (w_accept) begin
            r_read  <= 1'b0;
            r_write <= 1'b0;
        end
    end

    // Response registers: read data capture in RESP, done pulse out of ACK.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_f_rdata <= '0;
            r_d_rdata <= '0;
            r_f_done  <= 1'b0;
            r_d_done  <= 1'b0;
        end else begin
            r_f_done <= (r_state == ACK) && (r_owner == REQ_F);
            r_d_done <= (r_state == ACK) && (r_owner == REQ_D);
            if (r_state == RESP) begin
                if (r_owner == REQ_F) r_f_rdata <= readdata;
                else                  r_d_rdata <= readdata;
            end
        end
    end

    assign address    = r_address;
    assign read       = r_read;
    assign write      = r_write;
    assign writedata  = r_writedata;
    assign byteenable = r_byteenable;
    assign f_rdata    = r_f_rdata;
    assign d_rdata    = r_d_rdata;
    assign f_done     = r_f_done;
    assign d_done     = r_d_done;

endmodule
